// File: rtl/fpga_cfg_loader_pkg.sv
// fpga_cfg_loader_pkg
// Shared definitions for the configuration loader. It holds the fabric
// geometry, the select-bus widths derived from it, the slice offsets of each
// bus inside the flat config vector CFG, the frame length, and the loader
// state encoding.
// The concatenation order of CFG, from LSB upward, is
// brb, bsb, lb, leftio, rightio, topio, bottomio.
package fpga_cfg_loader_pkg;

  localparam int WIRE_WIDTH  = 7;
  localparam int LB_CFG_SIZE = 18;
  localparam int FPGA_WIDTH  = 5;
  localparam int FPGA_HEIGHT = 5;
  localparam int DATA_W      = 8;

  localparam logic [DATA_W-1:0] SYNC_WORD = 8'hA5;

  // Select-bus widths
  localparam int BRB_BITS  = FPGA_HEIGHT * FPGA_WIDTH * WIRE_WIDTH * 12;
  localparam int BSB_BITS  = (FPGA_HEIGHT - 1) * (FPGA_WIDTH - 1) * WIRE_WIDTH * WIRE_WIDTH * 12;
  localparam int LB_BITS   = FPGA_WIDTH * FPGA_HEIGHT * LB_CFG_SIZE;
  localparam int LRIO_BITS = FPGA_HEIGHT * 2 * WIRE_WIDTH;
  localparam int TBIO_BITS = FPGA_WIDTH * 2 * WIRE_WIDTH;

  // Bit offsets of each bus inside CFG
  localparam int BRB_OFF     = 0;
  localparam int BSB_OFF     = BRB_OFF + BRB_BITS;
  localparam int LB_OFF      = BSB_OFF + BSB_BITS;
  localparam int LEFTIO_OFF  = LB_OFF + LB_BITS;
  localparam int RIGHTIO_OFF = LEFTIO_OFF + LRIO_BITS;
  localparam int TOPIO_OFF   = RIGHTIO_OFF + LRIO_BITS;
  localparam int BOTIO_OFF   = TOPIO_OFF + TBIO_BITS;
  localparam int TOTAL_BITS  = BOTIO_OFF + TBIO_BITS;

  // Payload words per frame and the width of the counter that indexes them
  localparam int NWORDS = (TOTAL_BITS + DATA_W - 1) / DATA_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } cfg_state_e;

  // Running frame checksum: XOR of every payload word
  function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_shadow.sv
// cfg_shadow_reg
// Holds the configuration while a frame is being received. Each payload word
// has its own register, and a register is written only when its index is
// presented with we high. The upper bits of the last word do not map onto
// CFG, so no storage is built for them.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the shadow)
//   we         : write the word at widx
//   widx       : payload word index (0 .. NWORDS-1)
//   wdata      : payload word
//   cfg        : the full TOTAL_BITS shadow vector
module cfg_shadow_reg
  import fpga_cfg_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [CNT_W-1:0]      widx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [TOTAL_BITS-1:0] cfg
);

  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    localparam int LO = w * DATA_W;
    localparam int HI = ((LO + DATA_W) > TOTAL_BITS) ? (TOTAL_BITS - 1) : (LO + DATA_W - 1);

    logic [HI-LO:0] word_r;

    // Per-word storage, written when this word's index comes by
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_r <= '0;
      end else if (we && (widx == CNT_W'(w))) begin
        word_r <= wdata[HI-LO:0];
      end
    end

    assign cfg[HI:LO] = word_r;
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
// Configuration writer for fpga_top. It receives the frame
// SYNC_WORD, NWORDS payload words, XOR checksum
// over a valid/ready stream. The payload is collected in a shadow register.
// When the checksum matches, all select buses are updated together in one
// clock edge. A bad checksum leaves the previous configuration in place.
// Ports:
//   clk, rst_n          : fabric clock, asynchronous active-low reset
//   in_data, in_valid   : stream word and its qualifier
//   in_ready            : high in IDLE/LOAD/CHECK, decoded from state only
//   cfg_restart         : leave DONE/ERROR and go back to IDLE
//   cfg_busy            : frame in progress (LOAD or CHECK)
//   cfg_done, cfg_error : result of the last frame
//   *select             : fabric select buses, sliced from the applied CFG
module fpga_cfg_loader
  import fpga_cfg_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 cfg_restart,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_error,
  output logic [BRB_BITS-1:0]  brbselect,
  output logic [BSB_BITS-1:0]  bsbselect,
  output logic [LB_BITS-1:0]   lbselect,
  output logic [LRIO_BITS-1:0] leftioselect,
  output logic [LRIO_BITS-1:0] rightioselect,
  output logic [TBIO_BITS-1:0] topioselect,
  output logic [TBIO_BITS-1:0] bottomioselect
);

  cfg_state_e              state_r, state_next_s;
  logic [CNT_W-1:0]        count_r, count_next_s;
  logic [DATA_W-1:0]       csum_r, csum_next_s;
  logic                    shadow_we_s;
  logic                    apply_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    busy_r, done_r, error_r;
  logic [TOTAL_BITS-1:0]   shadow_cfg_s;
  logic [TOTAL_BITS-1:0]   cfg_r;

  cfg_shadow_reg u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (shadow_we_s),
    .widx  (count_r),
    .wdata (in_data),
    .cfg   (shadow_cfg_s)
  );

  // Ready decode: depends on state only, so it never waits on in_valid
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_LOAD, ST_CHECK: in_ready_s = 1'b1;
      default:                    in_ready_s = 1'b0;
    endcase
  end

  assign in_ready = in_ready_s;
  assign accept_s = in_valid & in_ready_s;

  // Next state, word counter, checksum and shadow/apply strobes
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    csum_next_s  = csum_r;
    shadow_we_s  = 1'b0;
    apply_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (in_data == SYNC_WORD)) begin
          state_next_s = ST_LOAD;
          count_next_s = '0;
          csum_next_s  = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          shadow_we_s  = 1'b1;
          csum_next_s  = csum_fold(csum_r, in_data);
          count_next_s = count_r + CNT_W'(1);
          // The last payload word moves us on, so the counter never wraps
          if (count_r == CNT_W'(NWORDS - 1)) begin
            state_next_s = ST_CHECK;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (in_data == csum_r) begin
            apply_s      = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ERROR;
          end
        end else begin
          state_next_s = ST_CHECK;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (cfg_restart) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Word counter and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      csum_r  <= '0;
    end else begin
      count_r <= count_next_s;
      csum_r  <= csum_next_s;
    end
  end

  // Status flags are registered from the next state, so they track state_r exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      busy_r  <= (state_next_s == ST_LOAD) || (state_next_s == ST_CHECK);
      done_r  <= (state_next_s == ST_DONE);
      error_r <= (state_next_s == ST_ERROR);
    end
  end

  // Applied configuration: the whole shadow is copied in one edge on a good checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r <= '0;
    end else if (apply_s) begin
      cfg_r <= shadow_cfg_s;
    end
  end

  assign cfg_busy  = busy_r;
  assign cfg_done  = done_r;
  assign cfg_error = error_r;

  assign brbselect      = cfg_r[BRB_OFF     +: BRB_BITS];
  assign bsbselect      = cfg_r[BSB_OFF     +: BSB_BITS];
  assign lbselect       = cfg_r[LB_OFF      +: LB_BITS];
  assign leftioselect   = cfg_r[LEFTIO_OFF  +: LRIO_BITS];
  assign rightioselect  = cfg_r[RIGHTIO_OFF +: LRIO_BITS];
  assign topioselect    = cfg_r[TOPIO_OFF   +: TBIO_BITS];
  assign bottomioselect = cfg_r[BOTIO_OFF   +: TBIO_BITS];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader
// Scoreboard bench for fpga_cfg_loader. When a frame's checksum word is issued,
// the stimulus process pushes the expected outcome into a queue. The outcome is
// done or error, plus the configuration that should then be visible. A monitor
// process watches for cfg_done/cfg_error to rise, pops the queue and compares.
module tb_fpga_cfg_loader;
  import fpga_cfg_loader_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [DATA_W-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 cfg_restart;
  logic                 cfg_busy;
  logic                 cfg_done;
  logic                 cfg_error;
  logic [BRB_BITS-1:0]  brbselect;
  logic [BSB_BITS-1:0]  bsbselect;
  logic [LB_BITS-1:0]   lbselect;
  logic [LRIO_BITS-1:0] leftioselect;
  logic [LRIO_BITS-1:0] rightioselect;
  logic [TBIO_BITS-1:0] topioselect;
  logic [TBIO_BITS-1:0] bottomioselect;

  fpga_cfg_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cfg_restart    (cfg_restart),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                  is_err;
    logic [TOTAL_BITS-1:0] cfg;
  } exp_t;

  exp_t                  exp_q[$];
  int                    tests = 0;
  int                    fails = 0;
  logic [7:0]            payload [NWORDS];
  logic [TOTAL_BITS-1:0] applied_m;
  logic                  ev_prev;

  logic [TOTAL_BITS-1:0] got_cfg;
  assign got_cfg = {bottomioselect, topioselect, rightioselect, leftioselect,
                    lbselect, bsbselect, brbselect};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_cfg(input string name, input logic [TOTAL_BITS-1:0] exp);
    int ndiff;
    int first;
    ndiff = 0;
    first = -1;
    tests++;
    for (int b = 0; b < TOTAL_BITS; b++) begin
      if (got_cfg[b] !== exp[b]) begin
        ndiff++;
        if (first < 0) first = b;
      end
    end
    if (ndiff != 0) begin
      fails++;
      $display("FAIL %s: %0d config bits differ, first at bit %0d (got %b, expected %b)",
               name, ndiff, first, got_cfg[first], exp[first]);
    end
  endtask

  // Reference model: payload word i bit j lands on CFG bit i*DATA_W+j
  function automatic logic [TOTAL_BITS-1:0] model_cfg();
    logic [TOTAL_BITS-1:0] m;
    logic [7:0]            w;
    for (int b = 0; b < TOTAL_BITS; b++) begin
      w    = payload[b / DATA_W];
      m[b] = w[b % DATA_W];
    end
    return m;
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NWORDS; i++) x = x ^ payload[i];
    return x;
  endfunction

  // Monitor: on each rising cfg_done/cfg_error, pop the expected outcome and compare
  always @(negedge clk) begin
    exp_t e;
    logic ev_now;
    if (!rst_n) begin
      ev_prev = 1'b0;
    end else begin
      ev_now = cfg_done | cfg_error;
      if (ev_now && !ev_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'(ev_now), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_done", 32'(cfg_done), 32'(!e.is_err));
          chk("ev_error", 32'(cfg_error), 32'(e.is_err));
          chk("ev_in_ready", 32'(in_ready), 32'd0);
          chk("ev_busy", 32'(cfg_busy), 32'd0);
          chk_cfg("ev_cfg", e.cfg);
        end
      end
      ev_prev = ev_now;
    end
  end

  task automatic send_word(input logic [7:0] w, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One frame. abort_after >= 0 stops after that many payload words.
  task automatic run_frame(input logic [7:0] csum_flip, input bit gaps, input int abort_after);
    send_word(SYNC_WORD, gaps);
    for (int i = 0; i < NWORDS; i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      send_word(payload[i], gaps);
    end
    if (csum_flip == 8'h00) begin
      applied_m = model_cfg();
      exp_q.push_back('{is_err: 1'b0, cfg: applied_m});
    end else begin
      exp_q.push_back('{is_err: 1'b1, cfg: applied_m});
    end
    send_word(model_csum() ^ csum_flip, gaps);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(cfg_done || cfg_error)) chk("result_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    cfg_restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    applied_m = '0;
  endtask

  task automatic restart();
    cfg_restart = 1'b1;
    @(posedge clk);
    #1;
    cfg_restart = 1'b0;
    chk("restart_done", 32'(cfg_done), 32'd0);
    chk("restart_error", 32'(cfg_error), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    in_data     = 8'h00;
    in_valid    = 1'b0;
    cfg_restart = 1'b0;
    rst_n       = 1'b0;
    ev_prev     = 1'b0;
    #2;
    do_reset();

    // Reset state after an idle stretch
    repeat (10) @(posedge clk);
    #1;
    chk_cfg("reset_cfg", '0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_done", 32'(cfg_done), 32'd0);
    chk("reset_error", 32'(cfg_error), 32'd0);
    chk("reset_busy", 32'(cfg_busy), 32'd0);

    // Non-sync words in IDLE are dropped
    send_word(8'h00, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("idle_discard_busy", 32'(cfg_busy), 32'd0);

    // Good frame with counting pattern
    for (int i = 0; i < NWORDS; i++) payload[i] = 8'(i);
    send_word(SYNC_WORD, 1'b0);
    chk("load_busy", 32'(cfg_busy), 32'd1);
    // Finish this frame by hand (sync already sent)
    for (int i = 0; i < NWORDS; i++) send_word(payload[i], 1'b0);
    chk("check_busy", 32'(cfg_busy), 32'd1);
    applied_m = model_cfg();
    exp_q.push_back('{is_err: 1'b0, cfg: applied_m});
    send_word(model_csum(), 1'b0);
    wait_result();
    chk("brb_lo", 32'(brbselect[7:0]), 32'h00);
    chk("brb_hi", 32'(brbselect[15:8]), 32'h01);

    // Restart ignored in IDLE is not observable directly; go back and send a bad checksum
    restart();
    run_frame(8'h01, 1'b0, -1);
    wait_result();
    chk("bad_ready", 32'(in_ready), 32'd0);
    chk_cfg("bad_keeps_cfg", applied_m);

    // Same good frame with random valid gaps
    restart();
    run_frame(8'h00, 1'b1, -1);
    wait_result();

    // Random payload with gaps
    restart();
    for (int i = 0; i < NWORDS; i++) payload[i] = 8'($urandom);
    run_frame(8'h00, 1'b1, -1);
    wait_result();

    // Reset in the middle of a frame, then a full new frame
    restart();
    for (int i = 0; i < NWORDS; i++) payload[i] = 8'($urandom);
    run_frame(8'h00, 1'b0, 700);
    do_reset();
    #1;
    chk_cfg("midreset_cfg", '0);
    chk("midreset_busy", 32'(cfg_busy), 32'd0);
    for (int i = 0; i < NWORDS; i++) payload[i] = 8'($urandom);
    run_frame(8'h00, 1'b0, -1);
    wait_result();

    // All-ones frame: every select bit set, padding bits go nowhere
    restart();
    for (int i = 0; i < NWORDS; i++) payload[i] = 8'hFF;
    run_frame(8'h00, 1'b0, -1);
    wait_result();
    chk("ones_bot_msb", 32'(bottomioselect[TBIO_BITS-1]), 32'd1);
    chk("ones_all", 32'(&got_cfg), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
